// File: rtl/fifo_ctrl_param.sv
// Parametrised synchronous FIFO: one-hot write strobe into storage, occupancy flags,
// per-operation ack/error status and operation state. Define FIFO_ALMOST_EN for almost_full/almost_empty.
module fifo_ctrl_param #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 3
`ifdef FIFO_ALMOST_EN
  ,
  parameter int unsigned AF_LEVEL = (1 << ADDR_WIDTH) - 1,
  parameter int unsigned AE_LEVEL = 1
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic                         rd_en,
  input  logic [DATA_WIDTH-1:0]        din,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic [(1 << ADDR_WIDTH)-1:0] wr_sel,
  output logic                         full,
  output logic                         empty,
  output logic [ADDR_WIDTH:0]          data_count,
  output logic                         wr_ack,
  output logic                         wr_err,
  output logic                         rd_ack,
  output logic                         rd_err,
  output logic [2:0]                   state
`ifdef FIFO_ALMOST_EN
  ,
  output logic                         almost_full,
  output logic                         almost_empty
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_NO_OP    = 3'd1,
    ST_WRITE    = 3'd2,
    ST_WR_ERROR = 3'd3,
    ST_READ     = 3'd4,
    ST_RD_ERROR = 3'd5,
    ST_RDWR     = 3'd6
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_wr_ptr;
  logic [ADDR_WIDTH-1:0]   r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic                    r_full;
  logic                    r_empty;
  logic [DATA_WIDTH-1:0]   r_dout;
  logic                    r_wr_ack;
  logic                    r_wr_err;
  logic                    r_rd_ack;
  logic                    r_rd_err;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_wr_ok;
  logic                    w_rd_ok;
  logic [CW-1:0]           w_count_nxt;
  logic [DEPTH-1:0]        w_wr_sel;

  // Write and read are accepted independently; reset blocks both
  assign w_wr_ok     = wr_en && !r_full  && !reset;
  assign w_rd_ok     = rd_en && !r_empty && !reset;
  assign w_count_nxt = r_count + CW'(w_wr_ok) - CW'(w_rd_ok);

  always_comb begin
    w_wr_sel = '0;
    if (w_wr_ok) w_wr_sel[r_wr_ptr] = 1'b1;
  end

  // Storage is not reset; the strobe is the only write enable
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_wr_sel[i]) r_mem[i] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_INIT;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_dout   <= '0;
      r_wr_ack <= 1'b0;
      r_wr_err <= 1'b0;
      r_rd_ack <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
        r_dout   <= r_mem[r_rd_ptr];
      end
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == CW'(DEPTH));
      r_empty  <= (w_count_nxt == '0);
      r_wr_ack <= w_wr_ok;
      r_wr_err <= wr_en && !w_wr_ok;
      r_rd_ack <= w_rd_ok;
      r_rd_err <= rd_en && !w_rd_ok;
      // With both requests, the rejected side names the error state
      if (wr_en && rd_en) begin
        if (w_wr_ok && w_rd_ok) r_state <= ST_RDWR;
        else if (!w_rd_ok)      r_state <= ST_RD_ERROR;
        else                    r_state <= ST_WR_ERROR;
      end else if (wr_en) begin
        r_state <= w_wr_ok ? ST_WRITE : ST_WR_ERROR;
      end else if (rd_en) begin
        r_state <= w_rd_ok ? ST_READ : ST_RD_ERROR;
      end else begin
        r_state <= ST_NO_OP;
      end
    end
  end

`ifdef FIFO_ALMOST_EN
  logic r_almost_full;
  logic r_almost_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_almost_full  <= (32'(w_count_nxt) >= AF_LEVEL);
      r_almost_empty <= (32'(w_count_nxt) <= AE_LEVEL);
    end
  end

  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
`endif

  assign dout       = r_dout;
  assign wr_sel     = w_wr_sel;
  assign full       = r_full;
  assign empty      = r_empty;
  assign data_count = r_count;
  assign wr_ack     = r_wr_ack;
  assign wr_err     = r_wr_err;
  assign rd_ack     = r_rd_ack;
  assign rd_err     = r_rd_err;
  assign state      = r_state;

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Directed self-checking bench for fifo_ctrl_param at DEPTH=8, DATA_WIDTH=32.
module tb_fifo_ctrl_param;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 3;

  localparam logic [2:0] S_INIT = 3'd0, S_NOOP = 3'd1, S_WR = 3'd2, S_WRE = 3'd3,
                         S_RD = 3'd4, S_RDE = 3'd5, S_RDWR = 3'd6;

  logic          clk = 1'b0;
  logic          reset, wr_en, rd_en;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic [7:0]    wr_sel;
  logic          full, empty, wr_ack, wr_err, rd_ack, rd_err;
  logic [AW:0]   data_count;
  logic [2:0]    state;
`ifdef FIFO_ALMOST_EN
  logic          almost_full, almost_empty;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fifo_ctrl_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .din(din),
    .dout(dout), .wr_sel(wr_sel), .full(full), .empty(empty),
    .data_count(data_count), .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_ack(rd_ack), .rd_err(rd_err), .state(state)
`ifdef FIFO_ALMOST_EN
    , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag, input logic [2:0] st, input int cnt,
                            input logic wa, input logic we, input logic ra, input logic re);
    chk({tag, ".state"}, 64'(state), 64'(st));
    chk({tag, ".count"}, 64'(data_count), 64'(cnt));
    chk({tag, ".full"}, 64'(full), 64'(cnt == 8));
    chk({tag, ".empty"}, 64'(empty), 64'(cnt == 0));
    chk({tag, ".wr_ack"}, 64'(wr_ack), 64'(wa));
    chk({tag, ".wr_err"}, 64'(wr_err), 64'(we));
    chk({tag, ".rd_ack"}, 64'(rd_ack), 64'(ra));
    chk({tag, ".rd_err"}, 64'(rd_err), 64'(re));
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    tick();
    chk_status("reset", S_INIT, 0, 0, 0, 0, 0);
    chk("reset.dout", 64'(dout), 64'h0);
    chk("reset.wr_sel", 64'(wr_sel), 64'h0);
`ifdef FIFO_ALMOST_EN
    chk("reset.af", 64'(almost_full), 64'h0);
    chk("reset.ae", 64'(almost_empty), 64'h1);
`endif

    reset = 1'b0;
    tick(); tick();
    chk_status("idle", S_NOOP, 0, 0, 0, 0, 0);
    chk("idle.dout", 64'(dout), 64'h0);

    // Fill: 0x11..0x88, strobe walks one bit per write
    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = DW'(32'h11 * (i + 1));
      #1;
      chk($sformatf("fill%0d.wr_sel", i), 64'(wr_sel), 64'(8'h01 << i));
      tick();
      chk_status($sformatf("fill%0d", i), S_WR, i + 1, 1, 0, 0, 0);
    end

    din = 32'h99;
    #1;
    chk("ovf.wr_sel", 64'(wr_sel), 64'h0);
    tick();
    chk_status("ovf", S_WRE, 8, 0, 1, 0, 0);

    // Drain in order
    wr_en = 1'b0; rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_status($sformatf("drain%0d", i), S_RD, 7 - i, 0, 0, 1, 0);
      chk($sformatf("drain%0d.dout", i), 64'(dout), 64'(32'h11 * (i + 1)));
`ifdef FIFO_ALMOST_EN
      chk($sformatf("drain%0d.af", i), 64'(almost_full), 64'((7 - i) >= 7));
      chk($sformatf("drain%0d.ae", i), 64'(almost_empty), 64'((7 - i) <= 1));
`endif
    end
    tick();
    chk_status("udf", S_RDE, 0, 0, 0, 0, 1);
    chk("udf.dout", 64'(dout), 64'h88);

    // Count 3 at pointer 0, then 10 simultaneous read/write cycles across the wrap
    rd_en = 1'b0; wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = DW'(i + 1);
      tick();
    end
    chk_status("pre_rdwr", S_WR, 3, 1, 0, 0, 0);
    rd_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      din = DW'(32'hA0 + k);
      #1;
      chk($sformatf("rdwr%0d.wr_sel", k), 64'(wr_sel), 64'(8'h01 << ((3 + k) % 8)));
      tick();
      chk_status($sformatf("rdwr%0d", k), S_RDWR, 3, 1, 0, 1, 0);
      chk($sformatf("rdwr%0d.dout", k), 64'(dout), (k < 3) ? 64'(k + 1) : 64'(32'hA0 + k - 3));
    end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("tail%0d.dout", i), 64'(dout), 64'(32'hA7 + i));
    end
    chk_status("tail", S_RD, 0, 0, 0, 1, 0);

    // Both requests on empty: write taken, read rejected
    wr_en = 1'b1; rd_en = 1'b1; din = 32'h5A;
    tick();
    chk_status("both_empty", S_RDE, 1, 1, 0, 0, 1);
    chk("both_empty.dout", 64'(dout), 64'hA9);

    rd_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      din = DW'(32'h61 + i);
      tick();
    end
    chk_status("refill", S_WR, 8, 1, 0, 0, 0);

    // Both requests on full: read taken, write rejected
    rd_en = 1'b1; din = 32'hFF;
    tick();
    chk_status("both_full", S_WRE, 7, 0, 1, 1, 0);
    chk("both_full.dout", 64'(dout), 64'h5A);

    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_full%0d.dout", i), 64'(dout), 64'(32'h61 + i));
    end
    chk_status("cnt4", S_RD, 4, 0, 0, 1, 0);

    // Reset alongside a write discards it
    rd_en = 1'b0; wr_en = 1'b1; reset = 1'b1; din = 32'hEE;
    #1;
    chk("rst_wr.wr_sel", 64'(wr_sel), 64'h0);
    tick();
    chk_status("rst_wr", S_INIT, 0, 0, 0, 0, 0);
    chk("rst_wr.dout", 64'(dout), 64'h0);

    // Post-reset: first cycle resolves normally, pointers restart at 0
    reset = 1'b0; din = 32'h77;
    #1;
    chk("post_rst.wr_sel", 64'(wr_sel), 64'h01);
    tick();
    chk_status("post_rst_wr", S_WR, 1, 1, 0, 0, 0);
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    chk_status("post_rst_rd", S_RD, 0, 0, 0, 1, 0);
    chk("post_rst_rd.dout", 64'(dout), 64'h77);
    rd_en = 1'b0;
    tick();
    chk_status("final_idle", S_NOOP, 0, 0, 0, 0, 0);
    chk("final_idle.dout", 64'(dout), 64'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
